// File: rtl/sparse_pixel_index_queue.sv
// Thresholded pixel-index queue: enqueues indexes of pixels above a per-frame threshold.
// Optional SPARSE_QUEUE_VALUE_EN also stores each pixel value and adds the valueOut port.
module sparse_pixel_index_queue #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned PIXEL_COUNT = 784,
  parameter int unsigned QUEUE_DEPTH = 784,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frameStart,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  input  logic                   pixelValid,
  input  logic [PIXEL_WIDTH-1:0] pixelValue,
  output logic                   pixelReady,
  input  logic                   deqReady,
  output logic                   deqValid,
  output logic [INDEX_WIDTH-1:0] indexOut,
  output logic [COUNT_WIDTH-1:0] queueCount,
  output logic                   frameDone,
  output logic                   queueEmpty
`ifdef SPARSE_QUEUE_VALUE_EN
  ,
  output logic [PIXEL_WIDTH-1:0] valueOut
`endif
);

  localparam int unsigned PtrWidth = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PtrWidth-1:0]    LastPtr   = PtrWidth'(QUEUE_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FullCount = COUNT_WIDTH'(QUEUE_DEPTH);
  localparam logic [INDEX_WIDTH-1:0] LastIndex = INDEX_WIDTH'(PIXEL_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [PIXEL_WIDTH-1:0] thresh_q, thresh_d;
  logic [INDEX_WIDTH-1:0] index_hold_q;
  logic [INDEX_WIDTH-1:0] index_mem_q [QUEUE_DEPTH];

  logic accept, enq, deq;

  // Full is taken from the registered count, so a dequeue frees space only from the next cycle.
  assign pixelReady = (state_q == StFill) && (count_q != FullCount);
  assign deqValid   = (count_q != '0);
  assign accept     = pixelValid && pixelReady && !frameStart;
  assign enq        = accept && (pixelValue > thresh_q);
  assign deq        = deqValid && deqReady && !frameStart;

  assign queueCount = count_q;
  assign frameDone  = (state_q == StDrain);
  assign queueEmpty = frameDone && (count_q == '0);
  assign indexOut   = deqValid ? index_mem_q[rd_ptr_q] : index_hold_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    index_d  = index_q;
    thresh_d = thresh_q;
    if (frameStart) begin
      state_d  = StFill;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      index_d  = '0;
      thresh_d = threshold;
    end else begin
      if (accept) begin
        index_d = index_q + INDEX_WIDTH'(1);
        if (index_q == LastIndex) state_d = StDrain;
      end
      if (enq) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
      if (deq) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + COUNT_WIDTH'(1);
        2'b01:   count_d = count_q - COUNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      index_q      <= '0;
      thresh_q     <= '0;
      index_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      index_q      <= index_d;
      thresh_q     <= thresh_d;
      index_hold_q <= indexOut;
    end
  end

  // Storage is never reset; deqValid gates every read.
  always_ff @(posedge clk) begin
    if (enq) index_mem_q[wr_ptr_q] <= index_q;
  end

`ifdef SPARSE_QUEUE_VALUE_EN
  logic [PIXEL_WIDTH-1:0] value_hold_q;
  logic [PIXEL_WIDTH-1:0] value_mem_q [QUEUE_DEPTH];

  assign valueOut = deqValid ? value_mem_q[rd_ptr_q] : value_hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_hold_q <= '0;
    else       value_hold_q <= valueOut;
  end

  always_ff @(posedge clk) begin
    if (enq) value_mem_q[wr_ptr_q] <= pixelValue;
  end
`endif

endmodule

// File: tb/tb_sparse_pixel_index_queue.sv
// Directed bench for sparse_pixel_index_queue: full-depth instance plus a 4-entry instance
// sharing the same stimulus.
module tb_sparse_pixel_index_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [7:0]  threshold;
  logic        pixel_valid;
  logic [7:0]  pixel_value;
  logic        deq_ready;

  logic        pixel_ready, deq_valid, frame_done, queue_empty;
  logic [9:0]  index_out;
  logic [10:0] queue_count;
  logic        pixel_ready_4, deq_valid_4, frame_done_4, queue_empty_4;
  logic [9:0]  index_out_4;
  logic [10:0] queue_count_4;
`ifdef SPARSE_QUEUE_VALUE_EN
  logic [7:0]  value_out, value_out_4;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int deq_log[$];
  int deq_log4[$];

  sparse_pixel_index_queue dut (
    .clk(clk), .reset(reset), .frameStart(frame_start), .threshold(threshold),
    .pixelValid(pixel_valid), .pixelValue(pixel_value), .pixelReady(pixel_ready),
    .deqReady(deq_ready), .deqValid(deq_valid), .indexOut(index_out),
    .queueCount(queue_count), .frameDone(frame_done), .queueEmpty(queue_empty)
`ifdef SPARSE_QUEUE_VALUE_EN
    , .valueOut(value_out)
`endif
  );

  sparse_pixel_index_queue #(.QUEUE_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .frameStart(frame_start), .threshold(threshold),
    .pixelValid(pixel_valid), .pixelValue(pixel_value), .pixelReady(pixel_ready_4),
    .deqReady(deq_ready), .deqValid(deq_valid_4), .indexOut(index_out_4),
    .queueCount(queue_count_4), .frameDone(frame_done_4), .queueEmpty(queue_empty_4)
`ifdef SPARSE_QUEUE_VALUE_EN
    , .valueOut(value_out_4)
`endif
  );

  always #5 clk = ~clk;

  // Record dequeue handshakes seen just before the edge, then advance one cycle.
  task automatic tick();
    if (deq_valid && deq_ready) deq_log.push_back(int'(index_out));
    if (deq_valid_4 && deq_ready) deq_log4.push_back(int'(index_out_4));
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] thr);
    frame_start = 1'b1;
    threshold   = thr;
    tick();
    frame_start = 1'b0;
    deq_log.delete();
    deq_log4.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; threshold = 8'h00;
    pixel_valid = 1'b0; pixel_value = 8'h00; deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({pixel_ready, deq_valid, frame_done, queue_empty} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000",
               {pixel_ready, deq_valid, frame_done, queue_empty});
    end
    tests_run++;
    if (queue_count !== 11'd0 || index_out !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_count_index: got count %0d index %0d expected 0 0",
               queue_count, index_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mid_fill_reset();
    start_frame(8'h00);
    pixel_valid = 1'b1; pixel_value = 8'hFF; deq_ready = 1'b0;
    repeat (5) tick();
    pixel_valid = 1'b0;
    tests_run++;
    if (queue_count !== 11'd5) begin
      tests_failed++;
      $display("FAIL midfill_count: got %0d expected 5", queue_count);
    end
    deq_ready = 1'b1;
    repeat (2) tick();
    deq_ready = 1'b0;
    tests_run++;
    if (queue_count !== 11'd3 || index_out !== 10'd2) begin
      tests_failed++;
      $display("FAIL midfill_deq: got count %0d index %0d expected 3 2", queue_count, index_out);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({pixel_ready, deq_valid, frame_done, queue_empty} !== 4'b0000 ||
        queue_count !== 11'd0 || index_out !== 10'd0) begin
      tests_failed++;
      $display("FAIL midfill_reset: got flags %b count %0d index %0d expected 0000 0 0",
               {pixel_ready, deq_valid, frame_done, queue_empty}, queue_count, index_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_threshold();
    int idx = 0;
    int exp_idx[3] = '{3, 10, 783};
    start_frame(8'h80);
    deq_ready = 1'b1;
    for (int c = 0; c < 2000 && idx < 784; c++) begin
      pixel_valid = 1'b1;
      pixel_value = (idx == 3 || idx == 10 || idx == 783) ? 8'h81 : 8'h80;
      if (pixel_ready) idx++;
      tick();
    end
    pixel_valid = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (idx !== 784) begin
      tests_failed++;
      $display("FAIL thr_accepted: got %0d expected 784", idx);
    end
    tests_run++;
    if (deq_log.size() !== 3) begin
      tests_failed++;
      $display("FAIL thr_deq_count: got %0d expected 3", deq_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (deq_log[i] !== exp_idx[i]) begin
          tests_failed++;
          $display("FAIL thr_deq_index[%0d]: got %0d expected %0d", i, deq_log[i], exp_idx[i]);
        end
      end
    end
    tests_run++;
    if ({frame_done, queue_empty, deq_valid} !== 3'b110) begin
      tests_failed++;
      $display("FAIL thr_done_empty: got %b expected 110", {frame_done, queue_empty, deq_valid});
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    start_frame(8'h00);
    deq_ready = 1'b0; pixel_valid = 1'b1; pixel_value = 8'hFF;
    repeat (8) begin
      if (pixel_ready_4) n++;
      tick();
    end
    tests_run++;
    if (n !== 4 || queue_count_4 !== 11'd4 || pixel_ready_4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: got accepted %0d count %0d ready %b expected 4 4 0",
               n, queue_count_4, pixel_ready_4);
    end
    deq_ready = 1'b1;
    tests_run++;
    if (deq_valid_4 !== 1'b1 || index_out_4 !== 10'd0 || pixel_ready_4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_deq_cycle: got valid %b index %0d ready %b expected 1 0 0",
               deq_valid_4, index_out_4, pixel_ready_4);
    end
    tick();
    deq_ready = 1'b0;
    tests_run++;
    if (queue_count_4 !== 11'd3 || pixel_ready_4 !== 1'b1 || index_out_4 !== 10'd1) begin
      tests_failed++;
      $display("FAIL bp_release: got count %0d ready %b index %0d expected 3 1 1",
               queue_count_4, pixel_ready_4, index_out_4);
    end
    tick();
    pixel_valid = 1'b0;
    tests_run++;
    if (queue_count_4 !== 11'd4 || pixel_ready_4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_refill: got count %0d ready %b expected 4 0", queue_count_4, pixel_ready_4);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int max_cnt = 0;
    int max_cnt4 = 0;
    int bad = 0;
    int bad4 = 0;
    start_frame(8'h00);
    deq_ready = 1'b1; pixel_value = 8'hFF;
    for (int c = 0; c < 2000 && idx < 784; c++) begin
      pixel_valid = 1'b1;
      if (pixel_ready) idx++;
      if (int'(queue_count) > max_cnt) max_cnt = int'(queue_count);
      if (int'(queue_count_4) > max_cnt4) max_cnt4 = int'(queue_count_4);
      tick();
    end
    pixel_valid = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (max_cnt > 1 || max_cnt4 > 1) begin
      tests_failed++;
      $display("FAIL b2b_max_count: got %0d/%0d expected <=1", max_cnt, max_cnt4);
    end
    tests_run++;
    if (deq_log.size() !== 784 || deq_log4.size() !== 784) begin
      tests_failed++;
      $display("FAIL b2b_deq_total: got %0d/%0d expected 784",
               deq_log.size(), deq_log4.size());
    end else begin
      for (int i = 0; i < 784; i++) begin
        if (deq_log[i] != i) bad++;
        if (deq_log4[i] != i) bad4++;
      end
      tests_run++;
      if (bad !== 0 || bad4 !== 0) begin
        tests_failed++;
        $display("FAIL b2b_order: got %0d/%0d out-of-order entries expected 0", bad, bad4);
      end
    end
    tests_run++;
    if (queue_empty !== 1'b1 || queue_empty_4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_empty: got %b%b expected 11", queue_empty, queue_empty_4);
    end
  endtask

  task automatic test_restart();
    int idx = 0;
    start_frame(8'h80);
    deq_ready = 1'b0;
    for (int c = 0; c < 1000 && idx < 400; c++) begin
      pixel_valid = 1'b1;
      pixel_value = (idx >= 388) ? 8'h90 : 8'h10;
      if (pixel_ready) idx++;
      tick();
    end
    tests_run++;
    if (queue_count !== 11'd12) begin
      tests_failed++;
      $display("FAIL restart_pre_count: got %0d expected 12", queue_count);
    end
    frame_start = 1'b1; threshold = 8'h00; pixel_value = 8'hFF; deq_ready = 1'b1;
    tick();
    frame_start = 1'b0; deq_ready = 1'b0;
    tests_run++;
    if (queue_count !== 11'd0 || deq_valid !== 1'b0 || pixel_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_clear: got count %0d valid %b ready %b expected 0 0 1",
               queue_count, deq_valid, pixel_ready);
    end
    tick();
    pixel_valid = 1'b0;
    tests_run++;
    if (deq_valid !== 1'b1 || index_out !== 10'd0 || queue_count !== 11'd1) begin
      tests_failed++;
      $display("FAIL restart_first_index: got valid %b index %0d count %0d expected 1 0 1",
               deq_valid, index_out, queue_count);
    end
  endtask

  task automatic test_all_inactive();
    int idx = 0;
    bit seen = 1'b0;
    start_frame(8'h00);
    deq_ready = 1'b1; pixel_value = 8'h00;
    for (int c = 0; c < 2000 && idx < 784; c++) begin
      pixel_valid = 1'b1;
      if (pixel_ready) idx++;
      if (deq_valid) seen = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
    tests_run++;
    if (idx !== 784 || frame_done !== 1'b1 || queue_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL inactive_done: got accepted %0d done %b empty %b expected 784 1 1",
               idx, frame_done, queue_empty);
    end
    repeat (3) begin
      if (deq_valid) seen = 1'b1;
      tick();
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL inactive_deq_valid: got deqValid seen %b expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_mid_fill_reset();
    test_threshold();
    test_backpressure();
    test_back_to_back();
    test_restart();
    test_all_inactive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
